// File: rtl/lc3_ctrl_pkg.sv
// Shared types for the LC-3 control sequencer: control word, state encoding, opcodes, mux selects.
// The IND_PTR state exists only when LC3_IND_EN is defined.
package lc3_ctrl_pkg;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_LD    = 4'b0010;
  localparam logic [3:0] OP_ST    = 4'b0011;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_LDI   = 4'b1010;
  localparam logic [3:0] OP_STI   = 4'b1011;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;
  localparam logic [3:0] OP_LEA   = 4'b1110;

  localparam logic [1:0] PCMUX_INC    = 2'b00;
  localparam logic [1:0] PCMUX_BUS    = 2'b01;
  localparam logic [1:0] PCMUX_ADDER  = 2'b10;
  localparam logic       ADDR1_PC     = 1'b0;
  localparam logic       ADDR1_SR1    = 1'b1;
  localparam logic [1:0] ADDR2_ZERO   = 2'b00;
  localparam logic [1:0] ADDR2_OFF6   = 2'b01;
  localparam logic [1:0] ADDR2_OFF9   = 2'b10;
  localparam logic [1:0] ADDR2_OFF11  = 2'b11;
  localparam logic       MARMUX_ZEXT  = 1'b0;
  localparam logic       MARMUX_ADDER = 1'b1;
  localparam logic [1:0] DRMUX_IR11   = 2'b00;
  localparam logic [1:0] DRMUX_R7     = 2'b01;
  localparam logic [1:0] SR1MUX_IR11  = 2'b00;
  localparam logic [1:0] SR1MUX_IR8   = 2'b01;
  localparam logic [1:0] ALUK_ADD     = 2'b00;
  localparam logic [1:0] ALUK_AND     = 2'b01;
  localparam logic [1:0] ALUK_NOT     = 2'b10;
  localparam logic [1:0] ALUK_PASSA   = 2'b11;

  typedef struct packed {
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_ben;
    logic       ld_reg;
    logic       ld_cc;
    logic       ld_pc;
    logic       ld_led;
    logic       gate_pc;
    logic       gate_mdr;
    logic       gate_alu;
    logic       gate_marmux;
    logic [1:0] pcmux;
    logic       addr1mux;
    logic [1:0] addr2mux;
    logic       marmux;
    logic [1:0] drmux;
    logic [1:0] sr1mux;
    logic       sr2mux;
    logic [1:0] aluk;
  } ctrl_t;

  typedef enum logic [4:0] {
    ST_HALTED, ST_FETCH, ST_RD, ST_LD_IR, ST_DECODE, ST_ADD, ST_AND, ST_NOT,
    ST_BR, ST_BR_TAKE, ST_JMP, ST_JSR_SAVE, ST_JSR_PC, ST_ADDR, ST_LEA,
    ST_ST_MDR, ST_WR, ST_LD_REG, ST_PAUSE1, ST_PAUSE2
`ifdef LC3_IND_EN
    , ST_IND_PTR
`endif
  } state_t;

  // Register-writing ALU operate: DR=IR[11:9], SR1=IR[8:6], SR2/imm chosen by IR[5].
  function automatic ctrl_t alu_ctrl(logic [1:0] aluk, logic sr2_imm);
    ctrl_t c;
    c          = '0;
    c.gate_alu = 1'b1;
    c.ld_reg   = 1'b1;
    c.ld_cc    = 1'b1;
    c.drmux    = DRMUX_IR11;
    c.sr1mux   = SR1MUX_IR8;
    c.sr2mux   = sr2_imm;
    c.aluk     = aluk;
    return c;
  endfunction

endpackage

// File: rtl/lc3_mem_wait.sv
// Loadable down-counter shared by memory read and write waits; done marks the last wait cycle.
module lc3_mem_wait (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] count,
  output logic       done
);

  logic [3:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (load) begin
      cnt_d  = load_val;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (cnt_q == 4'd0) busy_d = 1'b0;
      else               cnt_d  = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q  <= 4'd0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign count = cnt_q;
  assign done  = busy_q && (cnt_q == 4'd0);

endmodule

// File: rtl/lc3_ctrl_seq.sv
// LC-3 multicycle control sequencer; outputs are registered alongside the state they belong to.
// Define LC3_IND_EN to enable the LDI/STI indirect path through IND_PTR.
module lc3_ctrl_seq
  import lc3_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int WR_LAT  = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output ctrl_t      Ctrl,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output logic       Halted,
  output logic [4:0] dbg_state
);

  state_t     state_q, state_d, ret_q, ret_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic       oe_q, oe_d, we_q, we_d, halted_q, halted_d;
  logic       wt_load, wt_done;
  logic [3:0] wt_val, wt_count;
  logic       is_store, is_base;

  lc3_mem_wait u_wait (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (wt_load),
    .load_val (wt_val),
    .count    (wt_count),
    .done     (wt_done)
  );

  assign is_store = (Opcode == OP_ST) || (Opcode == OP_STR);
  assign is_base  = (Opcode == OP_LDR) || (Opcode == OP_STR);

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    case (state_q)
      ST_HALTED: if (Run) state_d = ST_FETCH;
      ST_FETCH: begin
        state_d = ST_RD;
        ret_d   = ST_LD_IR;
      end
      ST_RD:     if (wt_done) state_d = ret_q;
      ST_WR:     if (wt_done) state_d = ST_FETCH;
      ST_LD_IR:  state_d = ST_DECODE;
      ST_DECODE: begin
        case (Opcode)
          OP_ADD:   state_d = ST_ADD;
          OP_AND:   state_d = ST_AND;
          OP_NOT:   state_d = ST_NOT;
          OP_BR:    state_d = ST_BR;
          OP_JMP:   state_d = ST_JMP;
          OP_JSR:   state_d = ST_JSR_SAVE;
          OP_LD, OP_ST, OP_LDR, OP_STR: state_d = ST_ADDR;
          OP_LEA:   state_d = ST_LEA;
          OP_PAUSE: state_d = ST_PAUSE1;
`ifdef LC3_IND_EN
          OP_LDI, OP_STI: state_d = ST_ADDR;
`endif
          default:  state_d = ST_FETCH;
        endcase
      end
      ST_BR:       state_d = BEN ? ST_BR_TAKE : ST_FETCH;
      ST_JSR_SAVE: state_d = ST_JSR_PC;
      ST_ADDR: begin
        if (is_store) begin
          state_d = ST_ST_MDR;
        end else begin
          state_d = ST_RD;
          ret_d   = ST_LD_REG;
        end
`ifdef LC3_IND_EN
        // Indirect ops first fetch the pointer, whichever direction they go.
        if (Opcode == OP_LDI || Opcode == OP_STI) begin
          state_d = ST_RD;
          ret_d   = ST_IND_PTR;
        end
      end
      ST_IND_PTR: begin
        if (Opcode == OP_STI) begin
          state_d = ST_ST_MDR;
        end else begin
          state_d = ST_RD;
          ret_d   = ST_LD_REG;
        end
`endif
      end
      ST_ST_MDR: state_d = ST_WR;
      ST_PAUSE1: if (Continue) state_d = ST_PAUSE2;
      ST_PAUSE2: if (!Continue) state_d = ST_FETCH;
      default:   state_d = ST_FETCH;
    endcase

    wt_load = 1'b0;
    wt_val  = 4'd0;
    if (state_d == ST_RD && state_q != ST_RD) begin
      wt_load = 1'b1;
      wt_val  = 4'(MEM_LAT);
    end else if (state_d == ST_WR && state_q != ST_WR) begin
      wt_load = 1'b1;
      wt_val  = 4'(WR_LAT - 1);
    end
  end

  // Outputs are decoded from the state being entered so they line up with state_q.
  always_comb begin
    ctrl_d   = '0;
    oe_d     = 1'b0;
    we_d     = 1'b0;
    halted_d = 1'b0;
    case (state_d)
      ST_HALTED: halted_d = 1'b1;
      ST_FETCH: begin
        ctrl_d.gate_pc = 1'b1;
        ctrl_d.ld_mar  = 1'b1;
        ctrl_d.ld_pc   = 1'b1;
        ctrl_d.pcmux   = PCMUX_INC;
      end
      ST_RD: begin
        oe_d          = 1'b1;
        ctrl_d.ld_mdr = (state_q == ST_RD) && (wt_count == 4'd1);
      end
      ST_WR: we_d = 1'b1;
      ST_LD_IR: begin
        ctrl_d.gate_mdr = 1'b1;
        ctrl_d.ld_ir    = 1'b1;
      end
      ST_DECODE: ctrl_d.ld_ben = 1'b1;
      ST_ADD:    ctrl_d = alu_ctrl(ALUK_ADD, IR_5);
      ST_AND:    ctrl_d = alu_ctrl(ALUK_AND, IR_5);
      ST_NOT:    ctrl_d = alu_ctrl(ALUK_NOT, IR_5);
      ST_BR_TAKE: begin
        ctrl_d.ld_pc    = 1'b1;
        ctrl_d.pcmux    = PCMUX_ADDER;
        ctrl_d.addr1mux = ADDR1_PC;
        ctrl_d.addr2mux = ADDR2_OFF9;
      end
      ST_JMP: begin
        ctrl_d.ld_pc    = 1'b1;
        ctrl_d.pcmux    = PCMUX_ADDER;
        ctrl_d.addr1mux = ADDR1_SR1;
        ctrl_d.sr1mux   = SR1MUX_IR8;
        ctrl_d.addr2mux = ADDR2_ZERO;
      end
      ST_JSR_SAVE: begin
        ctrl_d.gate_pc = 1'b1;
        ctrl_d.ld_reg  = 1'b1;
        ctrl_d.drmux   = DRMUX_R7;
      end
      ST_JSR_PC: begin
        ctrl_d.ld_pc = 1'b1;
        ctrl_d.pcmux = PCMUX_ADDER;
        if (IR_11) begin
          ctrl_d.addr1mux = ADDR1_PC;
          ctrl_d.addr2mux = ADDR2_OFF11;
        end else begin
          ctrl_d.addr1mux = ADDR1_SR1;
          ctrl_d.sr1mux   = SR1MUX_IR8;
          ctrl_d.addr2mux = ADDR2_ZERO;
        end
      end
      ST_ADDR: begin
        ctrl_d.gate_marmux = 1'b1;
        ctrl_d.ld_mar      = 1'b1;
        ctrl_d.marmux      = MARMUX_ADDER;
        if (is_base) begin
          ctrl_d.addr1mux = ADDR1_SR1;
          ctrl_d.sr1mux   = SR1MUX_IR8;
          ctrl_d.addr2mux = ADDR2_OFF6;
        end else begin
          ctrl_d.addr1mux = ADDR1_PC;
          ctrl_d.addr2mux = ADDR2_OFF9;
        end
      end
`ifdef LC3_IND_EN
      ST_IND_PTR: begin
        ctrl_d.gate_mdr = 1'b1;
        ctrl_d.ld_mar   = 1'b1;
      end
`endif
      ST_LD_REG: begin
        ctrl_d.gate_mdr = 1'b1;
        ctrl_d.ld_reg   = 1'b1;
        ctrl_d.ld_cc    = 1'b1;
        ctrl_d.drmux    = DRMUX_IR11;
      end
      ST_LEA: begin
        ctrl_d.gate_marmux = 1'b1;
        ctrl_d.ld_reg      = 1'b1;
        ctrl_d.marmux      = MARMUX_ADDER;
        ctrl_d.addr1mux    = ADDR1_PC;
        ctrl_d.addr2mux    = ADDR2_OFF9;
        ctrl_d.drmux       = DRMUX_IR11;
      end
      ST_ST_MDR: begin
        ctrl_d.sr1mux   = SR1MUX_IR11;
        ctrl_d.aluk     = ALUK_PASSA;
        ctrl_d.gate_alu = 1'b1;
        ctrl_d.ld_mdr   = 1'b1;
      end
      ST_PAUSE1: ctrl_d.ld_led = (state_q != ST_PAUSE1);
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_HALTED;
      ret_q    <= ST_HALTED;
      ctrl_q   <= '0;
      oe_q     <= 1'b0;
      we_q     <= 1'b0;
      halted_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      ctrl_q   <= ctrl_d;
      oe_q     <= oe_d;
      we_q     <= we_d;
      halted_q <= halted_d;
    end
  end

  assign Ctrl      = ctrl_q;
  assign Mem_OE    = oe_q;
  assign Mem_WE    = we_q;
  assign Halted    = halted_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lc3_ctrl_seq.sv
// Bench for lc3_ctrl_seq: per-cycle expected control traces built from instruction-level rules.
// Two instances cover MEM_LAT=2/WR_LAT=3 and MEM_LAT=5/WR_LAT=1; honours LC3_IND_EN.
module tb_lc3_ctrl_seq;
  import lc3_ctrl_pkg::*;

  localparam int LAT_A = 2, WLAT_A = 3, LAT_B = 5, WLAT_B = 1;
  localparam int W = $bits(ctrl_t) + 3;

  // clock / reset
  logic Clk;
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Reset_a, Reset_b, Run_a, Run_b, Continue, IR_5, IR_11, BEN;
  logic [3:0] Opcode;
  ctrl_t      ctrl_a, ctrl_b;
  logic       oe_a, we_a, halted_a, oe_b, we_b, halted_b;
  logic [4:0] dbg_a, dbg_b;
  logic [W-1:0] vec_a, vec_b;

  lc3_ctrl_seq #(.MEM_LAT(LAT_A), .WR_LAT(WLAT_A)) dut_a (
    .Clk(Clk), .Reset(Reset_a), .Run(Run_a), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN), .Ctrl(ctrl_a), .Mem_OE(oe_a),
    .Mem_WE(we_a), .Halted(halted_a), .dbg_state(dbg_a)
  );

  lc3_ctrl_seq #(.MEM_LAT(LAT_B), .WR_LAT(WLAT_B)) dut_b (
    .Clk(Clk), .Reset(Reset_b), .Run(Run_b), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN), .Ctrl(ctrl_b), .Mem_OE(oe_b),
    .Mem_WE(we_b), .Halted(halted_b), .dbg_state(dbg_b)
  );

  assign vec_a = {ctrl_a, oe_a, we_a, halted_a};
  assign vec_b = {ctrl_b, oe_b, we_b, halted_b};

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic         cont_q[$];
  int           total, bad;
  logic [3:0]   nxt_op;
  logic         nxt_ir5, nxt_ir11, nxt_ben;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input ctrl_t c, input logic oe, input logic we, input logic cont);
    exp_q.push_back({c, oe, we, 1'b0});
    cont_q.push_back(cont);
  endtask

  task automatic push_read(input int lat);
    ctrl_t c;
    for (int i = 0; i <= lat; i++) begin
      c = '0;
      c.ld_mdr = (i == lat);
      push(c, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic push_write(input int n);
    ctrl_t c;
    c = '0;
    for (int i = 0; i < n; i++) push(c, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic push_st_mdr();
    ctrl_t c;
    c = '0; c.sr1mux = SR1MUX_IR11; c.aluk = 2'b11; c.gate_alu = 1'b1; c.ld_mdr = 1'b1;
    push(c, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_ld_reg();
    ctrl_t c;
    c = '0; c.gate_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1; c.drmux = DRMUX_IR11;
    push(c, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_addr(input logic [3:0] op);
    ctrl_t c;
    c = '0; c.gate_marmux = 1'b1; c.ld_mar = 1'b1; c.marmux = MARMUX_ADDER;
    if (op == 4'b0110 || op == 4'b0111) begin
      c.addr1mux = ADDR1_SR1; c.sr1mux = SR1MUX_IR8; c.addr2mux = ADDR2_OFF6;
    end else begin
      c.addr1mux = ADDR1_PC; c.addr2mux = ADDR2_OFF9;
    end
    push(c, 1'b0, 1'b0, 1'b0);
  endtask

  // Expected cycle-by-cycle trace of one instruction, starting with its FETCH.
  task automatic build(input logic [3:0] op, input logic ir5, input logic ir11, input logic ben,
                       input int lat, input int wlat, input int p_n, input int h_n);
    ctrl_t c;
    c = '0; c.gate_pc = 1'b1; c.ld_mar = 1'b1; c.ld_pc = 1'b1; c.pcmux = PCMUX_INC;
    push(c, 1'b0, 1'b0, 1'b0);
    push_read(lat);
    c = '0; c.gate_mdr = 1'b1; c.ld_ir = 1'b1; push(c, 1'b0, 1'b0, 1'b0);
    c = '0; c.ld_ben = 1'b1; push(c, 1'b0, 1'b0, 1'b0);
    case (op)
      4'b0001, 4'b0101, 4'b1001: begin
        c = '0; c.gate_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
        c.drmux = DRMUX_IR11; c.sr1mux = SR1MUX_IR8; c.sr2mux = ir5;
        c.aluk = (op == 4'b0001) ? 2'b00 : (op == 4'b0101) ? 2'b01 : 2'b10;
        push(c, 1'b0, 1'b0, 1'b0);
      end
      4'b0000: begin
        c = '0; push(c, 1'b0, 1'b0, 1'b0);
        if (ben) begin
          c.ld_pc = 1'b1; c.pcmux = PCMUX_ADDER; c.addr1mux = ADDR1_PC; c.addr2mux = ADDR2_OFF9;
          push(c, 1'b0, 1'b0, 1'b0);
        end
      end
      4'b1100: begin
        c = '0; c.ld_pc = 1'b1; c.pcmux = PCMUX_ADDER; c.addr1mux = ADDR1_SR1;
        c.sr1mux = SR1MUX_IR8; c.addr2mux = ADDR2_ZERO;
        push(c, 1'b0, 1'b0, 1'b0);
      end
      4'b0100: begin
        c = '0; c.gate_pc = 1'b1; c.ld_reg = 1'b1; c.drmux = DRMUX_R7;
        push(c, 1'b0, 1'b0, 1'b0);
        c = '0; c.ld_pc = 1'b1; c.pcmux = PCMUX_ADDER;
        if (ir11) begin
          c.addr1mux = ADDR1_PC; c.addr2mux = ADDR2_OFF11;
        end else begin
          c.addr1mux = ADDR1_SR1; c.sr1mux = SR1MUX_IR8; c.addr2mux = ADDR2_ZERO;
        end
        push(c, 1'b0, 1'b0, 1'b0);
      end
      4'b0010, 4'b0110: begin
        push_addr(op); push_read(lat); push_ld_reg();
      end
      4'b0011, 4'b0111: begin
        push_addr(op); push_st_mdr(); push_write(wlat);
      end
      4'b1110: begin
        c = '0; c.gate_marmux = 1'b1; c.ld_reg = 1'b1; c.marmux = MARMUX_ADDER;
        c.addr1mux = ADDR1_PC; c.addr2mux = ADDR2_OFF9; c.drmux = DRMUX_IR11;
        push(c, 1'b0, 1'b0, 1'b0);
      end
      4'b1101: begin
        for (int i = 0; i < p_n; i++) begin
          c = '0; c.ld_led = (i == 0);
          push(c, 1'b0, 1'b0, (i == p_n - 1));
        end
        c = '0;
        for (int i = 0; i < h_n; i++) push(c, 1'b0, 1'b0, (i < h_n - 1));
      end
`ifdef LC3_IND_EN
      4'b1010, 4'b1011: begin
        push_addr(op); push_read(lat);
        c = '0; c.gate_mdr = 1'b1; c.ld_mar = 1'b1; push(c, 1'b0, 1'b0, 1'b0);
        if (op == 4'b1010) begin
          push_read(lat); push_ld_reg();
        end else begin
          push_st_mdr(); push_write(wlat);
        end
      end
`endif
      default: ;
    endcase
  endtask

  // driver: walks the expected trace, comparing up to max_n cycles, then empties the queue
  task automatic run_seq(input logic sel, input int max_n, input string tag);
    int n;
    n = 0;
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic         cn;
      e  = exp_q.pop_front();
      cn = cont_q.pop_front();
      if (n < max_n) begin
        step();
        check($sformatf("%s_c%0d", tag, n), sel ? vec_b : vec_a, e);
        if (n == 0) begin
          Opcode = nxt_op; IR_5 = nxt_ir5; IR_11 = nxt_ir11; BEN = nxt_ben;
        end
        Continue = cn;
        if (sel) Run_b = 1'($urandom_range(0, 1));
        else     Run_a = 1'($urandom_range(0, 1));
      end
      n++;
    end
  endtask

  task automatic run_instr(input logic sel, input logic [3:0] op, input logic ir5, input logic ir11,
                           input logic ben, input int p_n, input int h_n, input string tag);
    nxt_op = op; nxt_ir5 = ir5; nxt_ir11 = ir11; nxt_ben = ben;
    build(op, ir5, ir11, ben, sel ? LAT_B : LAT_A, sel ? WLAT_B : WLAT_A, p_n, h_n);
    run_seq(sel, 1000, tag);
  endtask

  task automatic check_halted(input logic sel, input string tag);
    ctrl_t z;
    z = '0;
    check(tag, sel ? vec_b : vec_a, {z, 1'b0, 1'b0, 1'b1});
  endtask

  initial begin
    total = 0; bad = 0;
    Reset_a = 1'b1; Reset_b = 1'b1; Run_a = 1'b0; Run_b = 1'b0; Continue = 1'b0;
    Opcode = 4'b0000; IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;
    repeat (3) step();
    check_halted(1'b0, "reset_a");
    check("reset_dbg", W'(dbg_a), W'(ST_HALTED));
    Reset_a = 1'b0;
    step(); check_halted(1'b0, "idle_a0");
    step(); check_halted(1'b0, "idle_a1");

    // directed instructions on the MEM_LAT=2, WR_LAT=3 instance
    Run_a = 1'b1;
    run_instr(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 1, 1, "add");
    run_instr(1'b0, 4'b0101, 1'b1, 1'b0, 1'b0, 1, 1, "and_imm");
    run_instr(1'b0, 4'b1001, 1'b1, 1'b0, 1'b0, 1, 1, "not");
    run_instr(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1, 1, "br_nt");
    run_instr(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1, 1, "br_t");
    run_instr(1'b0, 4'b1100, 1'b0, 1'b0, 1'b0, 1, 1, "jmp");
    run_instr(1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, 1, 1, "jsr");
    run_instr(1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 1, 1, "jsrr");
    run_instr(1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1, 1, "ld");
    run_instr(1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 1, 1, "ldr");
    run_instr(1'b0, 4'b0011, 1'b0, 1'b0, 1'b0, 1, 1, "st");
    run_instr(1'b0, 4'b0111, 1'b0, 1'b0, 1'b0, 1, 1, "str");
    run_instr(1'b0, 4'b1110, 1'b0, 1'b0, 1'b0, 1, 1, "lea");
    run_instr(1'b0, 4'b1101, 1'b0, 1'b0, 1'b0, 10, 2, "pause");
    run_instr(1'b0, 4'b1010, 1'b0, 1'b0, 1'b0, 1, 1, "ldi");
    run_instr(1'b0, 4'b1011, 1'b0, 1'b0, 1'b0, 1, 1, "sti");
    run_instr(1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 1, 1, "nop8");
    run_instr(1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 1, 1, "nopf");

    // random instruction stream
    for (int k = 0; k < 30; k++) begin
      run_instr(1'b0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(1, 4), $urandom_range(1, 3), $sformatf("rnd%0d", k));
    end

    // reset landing in the second read-wait cycle
    nxt_op = 4'b0001; nxt_ir5 = 1'b0; nxt_ir11 = 1'b0; nxt_ben = 1'b0;
    build(4'b0001, 1'b0, 1'b0, 1'b0, LAT_A, WLAT_A, 1, 1);
    run_seq(1'b0, 3, "rst_rd");
    Reset_a = 1'b1; Run_a = 1'b0;
    step();
    check_halted(1'b0, "rst_rd_halt");
    check("rst_rd_oe", W'(oe_a), W'(1'b0));
    Reset_a = 1'b0;
    step(); check_halted(1'b0, "rst_rd_idle");
    Run_a = 1'b1;
    run_instr(1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1, 1, "rst_rd_add");

    // MEM_LAT=5, WR_LAT=1 instance
    Reset_a = 1'b1; Run_a = 1'b0; Reset_b = 1'b0;
    step(); check_halted(1'b1, "idle_b");
    Run_b = 1'b1;
    run_instr(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1, 1, "b_add");
    run_instr(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1, 1, "b_ld");
    run_instr(1'b1, 4'b0111, 1'b0, 1'b0, 1'b0, 1, 1, "b_str");
    for (int k = 0; k < 6; k++) begin
      run_instr(1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(1, 3), $urandom_range(1, 2), $sformatf("b_rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
